// File: rtl/tilt_conditioner.sv
// tilt_conditioner: averages signed X/Y tilt samples over 2^AVG_LOG2-sample
// windows, applies a deadzone and publishes per-axis direction flags plus an
// 8-bit magnitude above the deadzone for the ball-motion block.
// Optional build macro: TILT_HYST_EN adds HYST-wide hysteresis so that a set
// direction flag is held until the magnitude falls to DEADZONE-HYST or below.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACCUM   | accepting samples; accumulates until the window is full
// COMPUTE | window averaged into avg registers, accumulators cleared
// PUBLISH | outputs reloaded from the averages, update pulses next cycle
module tilt_conditioner #(
  parameter int AVG_LOG2 = 2,
  parameter int DEADZONE = 8,
  parameter int HYST     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [7:0] x_sample,
  input  logic [7:0] y_sample,
  output logic       x_increment,
  output logic       x_decrement,
  output logic       y_increment,
  output logic       y_decrement,
  output logic [7:0] x_threshold,
  output logic [7:0] y_threshold,
  output logic       update
);

  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [7:0] DZ = 8'(DEADZONE);
`ifdef TILT_HYST_EN
  localparam logic [7:0] HB = 8'(DEADZONE - HYST);
`endif

  // Reject illegal parameterisations at elaboration time.
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
    $error("tilt_conditioner: AVG_LOG2 must be 0..4");
  end
  if (DEADZONE < 0 || DEADZONE > 126) begin : g_bad_dz
    $error("tilt_conditioner: DEADZONE must be 0..126");
  end
  if (HYST < 0 || HYST > DEADZONE) begin : g_bad_hyst
    $error("tilt_conditioner: HYST must be 0..DEADZONE");
  end

  typedef enum logic [1:0] {ACCUM, COMPUTE, PUBLISH} state_t;

  state_t state, state_nxt;
  logic armed;
  logic accept, last_accept;
  logic [CW-1:0] count;
  logic signed [AW-1:0] acc_x, acc_y;
  logic signed [AW-1:0] x_ext, y_ext;
  logic [7:0] avg_x, avg_y;
  logic x_inc_nxt, x_dec_nxt, y_inc_nxt, y_dec_nxt;
  logic [7:0] x_thr_nxt, y_thr_nxt;

  assign x_ext = AW'($signed(x_sample));
  assign y_ext = AW'($signed(y_sample));
  assign accept = sample_valid && sample_ready;
  assign last_accept = accept && (count == LAST);

  // Per-axis output rule: returns {increment, decrement, threshold}.
  // -128 has no positive 8-bit twin, so its magnitude saturates at 127.
`ifdef TILT_HYST_EN
  function automatic logic [9:0] eval_axis(input logic [7:0] avg,
                                           input logic prev_inc,
                                           input logic prev_dec);
`else
  function automatic logic [9:0] eval_axis(input logic [7:0] avg);
`endif
    logic [7:0] mag;
    if (avg == 8'h80) mag = 8'd127;
    else if (avg[7]) mag = -avg;
    else mag = avg;
`ifdef TILT_HYST_EN
    // A held flag survives while the sign matches and mag stays above the
    // lower band edge; threshold never drops to 0 while a flag is set.
    if (((prev_inc && !avg[7]) || (prev_dec && avg[7])) && (mag > HB))
      return {prev_inc, prev_dec, (mag > DZ) ? 8'(mag - DZ) : 8'd1};
`endif
    if (mag > DZ) return {~avg[7], avg[7], 8'(mag - DZ)};
    return 10'd0;
  endfunction

  // Next output values, consumed only in PUBLISH.
  always_comb begin
`ifdef TILT_HYST_EN
    {x_inc_nxt, x_dec_nxt, x_thr_nxt} = eval_axis(avg_x, x_increment, x_decrement);
    {y_inc_nxt, y_dec_nxt, y_thr_nxt} = eval_axis(avg_y, y_increment, y_decrement);
`else
    {x_inc_nxt, x_dec_nxt, x_thr_nxt} = eval_axis(avg_x);
    {y_inc_nxt, y_dec_nxt, y_thr_nxt} = eval_axis(avg_y);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_accept) state_nxt = COMPUTE;
      COMPUTE: state_nxt = PUBLISH;
      PUBLISH: state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // FSM outputs: ready only in ACCUM and only once armed after reset.
  always_comb begin
    sample_ready = armed && (state == ACCUM);
  end

  // Accumulators, window count and the averaged result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
      count <= '0;
      acc_x <= '0;
      acc_y <= '0;
      avg_x <= '0;
      avg_y <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        acc_x <= acc_x + x_ext;
        acc_y <= acc_y + y_ext;
        count <= (count == LAST) ? '0 : count + 1'b1;
      end
      if (state == COMPUTE) begin
        // Dropping the low AVG_LOG2 bits is an arithmetic shift (floor).
        avg_x <= acc_x[AW-1:AVG_LOG2];
        avg_y <= acc_y[AW-1:AVG_LOG2];
        acc_x <= '0;
        acc_y <= '0;
      end
    end
  end

  // Registered outputs, reloaded once per window, plus the update pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_increment <= 1'b0;
      x_decrement <= 1'b0;
      y_increment <= 1'b0;
      y_decrement <= 1'b0;
      x_threshold <= '0;
      y_threshold <= '0;
      update      <= 1'b0;
    end else begin
      update <= (state == PUBLISH);
      if (state == PUBLISH) begin
        x_increment <= x_inc_nxt;
        x_decrement <= x_dec_nxt;
        y_increment <= y_inc_nxt;
        y_decrement <= y_dec_nxt;
        x_threshold <= x_thr_nxt;
        y_threshold <= y_thr_nxt;
      end
    end
  end

endmodule
